// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter and RAW hazard scoreboard for the register bank
module regfile_wb_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                           arb_clk,
    input  logic                           arb_rst,
    input  logic [NUM_REQ-1:0]             arb_req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  arb_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  arb_req_data,
    output logic [NUM_REQ-1:0]             arb_req_ready,
    input  logic                           arb_rsv_en,
    input  logic [ADDR_WIDTH-1:0]          arb_rsv_addr,
    input  logic [ADDR_WIDTH-1:0]          arb_chk_addr_1,
    input  logic [ADDR_WIDTH-1:0]          arb_chk_addr_2,
    output logic                           arb_hazard_1,
    output logic                           arb_hazard_2,
    output logic                           arb_wr_en,
    output logic [ADDR_WIDTH-1:0]          arb_wr_addr,
    output logic [DATA_WIDTH-1:0]          arb_wr_data,
    output logic [31:0]                    arb_busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NREG  = 32;

    logic [PTR_W-1:0]      r_ptr;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [NREG-1:0]       r_busy;

    logic                  w_found;
    logic                  w_xfer;
    logic [PTR_W-1:0]      w_gnt_idx;
    logic [PTR_W-1:0]      w_ptr_next;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [NREG-1:0]       w_set;
    logic [NREG-1:0]       w_clr;
    logic [NREG-1:0]       w_busy_next;

    // Scan from the priority pointer; the first valid requester wins.
    always_comb begin
        int idx;
        idx       = 0;
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_found && arb_req_valid[idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = PTR_W'(idx);
            end
        end
    end

    assign w_xfer        = w_found & ~arb_rst;
    assign arb_req_ready = w_xfer ? (NUM_REQ'(1) << w_gnt_idx) : '0;
    assign w_sel_addr    = arb_req_addr[ADDR_WIDTH*w_gnt_idx +: ADDR_WIDTH];
    assign w_sel_data    = arb_req_data[DATA_WIDTH*w_gnt_idx +: DATA_WIDTH];
    assign w_ptr_next    = (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    // Set is applied after clear so a fresh reservation survives a same-cycle write-back.
    assign w_set       = (arb_rsv_en && arb_rsv_addr != '0) ? (NREG'(1) << arb_rsv_addr) : '0;
    assign w_clr       = (w_xfer && w_sel_addr != '0) ? (NREG'(1) << w_sel_addr) : '0;
    assign w_busy_next = ((r_busy & ~w_clr) | w_set) & ~NREG'(1);

    always_ff @(posedge arb_clk or posedge arb_rst) begin
        if (arb_rst) begin
            r_ptr     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= '0;
        end else begin
            r_busy  <= w_busy_next;
            r_wr_en <= w_xfer && (w_sel_addr != '0);
            if (w_xfer) begin
                r_ptr     <= w_ptr_next;
                r_wr_addr <= w_sel_addr;
                r_wr_data <= w_sel_data;
            end
        end
    end

    // The in-flight term covers the cycle between scoreboard clear and the bank write.
    assign arb_hazard_1 = ~arb_rst & (arb_chk_addr_1 != '0) &
                          (r_busy[arb_chk_addr_1] | (r_wr_en & (r_wr_addr == arb_chk_addr_1)));
    assign arb_hazard_2 = ~arb_rst & (arb_chk_addr_2 != '0) &
                          (r_busy[arb_chk_addr_2] | (r_wr_en & (r_wr_addr == arb_chk_addr_2)));

    assign arb_wr_en   = r_wr_en;
    assign arb_wr_addr = r_wr_addr;
    assign arb_wr_data = r_wr_data;
    assign arb_busy    = r_busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    localparam int NR = 3;
    localparam int DW = 32;
    localparam int AW = 5;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              rsv_en;
    logic [AW-1:0]     rsv_addr;
    logic [AW-1:0]     chk_addr_1;
    logic [AW-1:0]     chk_addr_2;
    logic              hazard_1;
    logic              hazard_2;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [31:0]       busy;

    int n_checks = 0;
    int n_errors = 0;

    regfile_wb_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .arb_clk        (clk),
        .arb_rst        (rst),
        .arb_req_valid  (req_valid),
        .arb_req_addr   (req_addr),
        .arb_req_data   (req_data),
        .arb_req_ready  (req_ready),
        .arb_rsv_en     (rsv_en),
        .arb_rsv_addr   (rsv_addr),
        .arb_chk_addr_1 (chk_addr_1),
        .arb_chk_addr_2 (chk_addr_2),
        .arb_hazard_1   (hazard_1),
        .arb_hazard_2   (hazard_2),
        .arb_wr_en      (wr_en),
        .arb_wr_addr    (wr_addr),
        .arb_wr_data    (wr_data),
        .arb_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_addr[AW*i +: AW] = a;
        req_data[DW*i +: DW] = d;
    endtask

    logic [NR-1:0] fair_exp [8];
    int gap;
    int max_gap;

    initial begin
        fair_exp = '{3'b001, 3'b010, 3'b100, 3'b010, 3'b100, 3'b010, 3'b100, 3'b010};
        rst = 1'b1;
        req_valid = '0; req_addr = '0; req_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; chk_addr_1 = '0; chk_addr_2 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_wr_en", wr_en, 0);
        check_eq("rst_wr_addr", wr_addr, 0);
        check_eq("rst_wr_data", wr_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ready", req_ready, 0);

        // Build a mid-write state: busy = x4, write to x9 in flight
        @(negedge clk);
        rsv_en = 1'b1; rsv_addr = 5'd4;
        set_req(0, 1'b1, 5'd9, 32'h11);
        #1 check_eq("pre_ready", req_ready, 3'b001);
        @(negedge clk);
        rsv_en = 1'b0;
        set_req(0, 1'b0, 5'd0, 32'h0);
        set_req(1, 1'b1, 5'd2, 32'h22);
        chk_addr_1 = 5'd4;
        #1;
        check_eq("pre_busy", busy, 32'h0000_0010);
        check_eq("pre_wr_en", wr_en, 1);
        check_eq("pre_wr_addr", wr_addr, 9);
        check_eq("pre_hazard", hazard_1, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_wr_en", wr_en, 0);
        check_eq("arst_wr_addr", wr_addr, 0);
        check_eq("arst_wr_data", wr_data, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_hazard", hazard_1, 0);
        check_eq("arst_ready", req_ready, 0);

        // Round-robin with all three valid
        @(negedge clk);
        rst = 1'b0;
        chk_addr_1 = '0;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(i + 1), 32'hA0 + i);
        #1;
        for (int c = 0; c < 6; c++) begin
            check_eq("rr_ready", req_ready, 64'(1 << (c % 3)));
            @(negedge clk);
            check_eq("rr_wr_en", wr_en, 1);
            check_eq("rr_wr_addr", wr_addr, 64'((c % 3) + 1));
            check_eq("rr_wr_data", wr_data, 64'(32'hA0 + (c % 3)));
            #1;
        end
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, '0, '0);
        @(negedge clk);
        check_eq("rr_idle_wr_en", wr_en, 0);
        check_eq("rr_idle_ready", req_ready, 0);

        // Scoreboard and hazard on x5
        rsv_en = 1'b1; rsv_addr = 5'd5; chk_addr_1 = 5'd5; chk_addr_2 = 5'd6;
        #1 check_eq("sb_same_cycle_hz", hazard_1, 0);
        @(negedge clk);
        rsv_en = 1'b0;
        #1;
        check_eq("sb_hz_after_rsv", hazard_1, 1);
        check_eq("sb_busy_set", busy, 32'h0000_0020);
        check_eq("sb_hz2_other", hazard_2, 0);
        @(negedge clk);
        set_req(1, 1'b1, 5'd5, 32'h55);
        #1;
        check_eq("sb_ready", req_ready, 3'b010);
        check_eq("sb_hz_hold", hazard_1, 1);
        @(negedge clk);
        set_req(1, 1'b0, '0, '0);
        #1;
        check_eq("sb_busy_clr", busy, 0);
        check_eq("sb_wr_en", wr_en, 1);
        check_eq("sb_wr_addr", wr_addr, 5);
        check_eq("sb_wr_data", wr_data, 32'h55);
        check_eq("sb_hz_inflight", hazard_1, 1);
        @(negedge clk);
        #1;
        check_eq("sb_hz_drop", hazard_1, 0);
        check_eq("sb_wr_en_drop", wr_en, 0);

        // Set/clear collision on x7 (pointer now at 2)
        rsv_en = 1'b1; rsv_addr = 5'd7;
        @(negedge clk);
        set_req(2, 1'b1, 5'd7, 32'h77);
        #1;
        check_eq("col_ready", req_ready, 3'b100);
        check_eq("col_busy_pre", busy, 32'h0000_0080);
        @(negedge clk);
        rsv_en = 1'b0;
        set_req(2, 1'b0, '0, '0);
        set_req(0, 1'b1, 5'd7, 32'h78);
        chk_addr_2 = 5'd7;
        #1;
        check_eq("col_busy_kept", busy, 32'h0000_0080);
        check_eq("col_wr_addr", wr_addr, 7);
        check_eq("col_hz2", hazard_2, 1);
        check_eq("col_ready2", req_ready, 3'b001);
        @(negedge clk);
        set_req(0, 1'b0, '0, '0);
        #1 check_eq("col_busy_clr", busy, 0);

        // x0 write from requester 1 (pointer now at 1)
        set_req(1, 1'b1, 5'd0, 32'hDEAD_BEEF);
        #1 check_eq("x0_ready", req_ready, 3'b010);
        @(negedge clk);
        set_req(1, 1'b0, '0, '0);
        check_eq("x0_wr_en", wr_en, 0);
        check_eq("x0_busy", busy, 0);
        set_req(0, 1'b1, 5'd3, 32'h33);
        set_req(2, 1'b1, 5'd3, 32'h33);
        #1 check_eq("x0_ptr_adv", req_ready, 3'b100);
        @(negedge clk);
        set_req(0, 1'b0, '0, '0);
        set_req(2, 1'b0, '0, '0);
        check_eq("x0_next_wr_addr", wr_addr, 3);
        rsv_en = 1'b1; rsv_addr = 5'd0; chk_addr_1 = 5'd0; chk_addr_2 = 5'd0;
        #1 check_eq("x0_hz1", hazard_1, 0);
        @(negedge clk);
        rsv_en = 1'b0;
        #1;
        check_eq("x0_rsv_busy", busy, 0);
        check_eq("x0_rsv_hz1", hazard_1, 0);
        check_eq("x0_rsv_hz2", hazard_2, 0);

        // Fairness: requester 2 held valid, 0 and 1 alternate (pointer now at 0)
        gap = 0;
        max_gap = 0;
        for (int c = 0; c < 8; c++) begin
            set_req(0, (c % 2) == 0, 5'd12, 32'h1200 + c);
            set_req(1, (c % 2) == 1, 5'd11, 32'h1100 + c);
            set_req(2, 1'b1, 5'd10, 32'h1000 + c);
            #1;
            check_eq("fair_ready", req_ready, 64'(fair_exp[c]));
            gap++;
            if (req_ready[2]) begin
                if (gap > max_gap) max_gap = gap;
                gap = 0;
            end
            @(negedge clk);
        end
        if (gap > max_gap) max_gap = gap;
        check_eq("fair_max_gap_ok", 64'(max_gap <= NR), 1);
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, '0, '0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and hazard scoreboard in front of the 32x32 register bank. It shares the bank's single write port between several producers (ALU, load unit, CSR path) in round-robin order, and drives the bank's write inputs from registers. It also tracks which architectural registers have writes outstanding so the decode stage can stall on read-after-write hazards.

## Interface
Parameters:
- NUM_REQ, 3, number of write-back requesters (2..8)
- DATA_WIDTH, 32, write data width
- ADDR_WIDTH, 5, register address width (32 registers)

Ports:
- arb_clk  input  1  clock; all state updates on the rising edge
- arb_rst  input  1  reset, asynchronous, active-high
- arb_req_valid  input  NUM_REQ  requester i has a write pending
- arb_req_addr  input  NUM_REQ*ADDR_WIDTH  destination for requester i, at bits [ADDR_WIDTH*i +: ADDR_WIDTH]
- arb_req_data  input  NUM_REQ*DATA_WIDTH  write data for requester i, at bits [DATA_WIDTH*i +: DATA_WIDTH]
- arb_req_ready  output  NUM_REQ  one-hot grant, combinational
- arb_rsv_en  input  1  decode issues an instruction with a destination register
- arb_rsv_addr  input  ADDR_WIDTH  destination register being reserved
- arb_chk_addr_1, arb_chk_addr_2  input  ADDR_WIDTH  source registers being decoded
- arb_hazard_1, arb_hazard_2  output  1  the matching source register is not yet readable
- arb_wr_en  output  1  registered write enable to the register bank
- arb_wr_addr  output  ADDR_WIDTH  registered write address
- arb_wr_data  output  DATA_WIDTH  registered write data
- arb_busy  output  32  scoreboard vector; bit n set means register n has a write outstanding

## Operation
- **Handshake:** a transfer on requester i happens when `arb_req_valid[i] & arb_req_ready[i]` are both high at a rising edge.
  - A requester holds valid, addr and data stable until it is granted.
  - Valid must not drop before the grant.
- **Arbitration:** round-robin with a priority pointer `ptr` (0..NUM_REQ-1).
  - The first valid requester found scanning `ptr, ptr+1, …` (mod NUM_REQ) is granted.
  - At most one ready is high. Ready is 0 for every requester when no valid is high.
- **Pointer update:** after a transfer on requester i, `ptr <= (i+1) mod NUM_REQ`. With no transfer, ptr holds.
- **No backpressure:** the bank always accepts a write. A grant is given every cycle any valid is high.
- **Write stage:** on a transfer, the next edge sets `arb_wr_en=1` and loads addr and data from the granted requester. With no transfer, `arb_wr_en=0` and addr/data hold their values.
- **x0 writes:** a transfer to address 0 is granted and consumed, but `arb_wr_en` stays 0.
- **Scoreboard** (`arb_busy`), updated at each edge:
  - Set: `arb_rsv_en` with `arb_rsv_addr != 0` sets its bit.
  - Clear: a transfer with addr a != 0 clears bit a.
  - Same register set and cleared in one cycle: set wins, because a new producer is outstanding.
  - Reserving an already-busy register leaves it at 1. The first write-back clears it; producers do not keep a count.
  - Bit 0 is always 0.
- **Hazard:** `arb_hazard_k = (chk_addr_k != 0) & (busy[chk_addr_k] | (arb_wr_en & arb_wr_addr == chk_addr_k))`.
  - This is combinational.
  - The second term covers the cycle between scoreboard clear and the bank write landing.
  - There is no forwarding.

## Timing
- **Reset:** asserting `arb_rst` immediately forces:
  - `arb_wr_en=0`, `arb_wr_addr=0`, `arb_wr_data=0`
  - `arb_busy=0`, `ptr=0`
  - `arb_hazard_*=0`, `arb_req_ready=0`
  A write in flight is dropped. The first grant is possible on the first edge after deassertion.
- **Latency:** handshake edge to the bank write edge is 1 cycle (the bank samples `arb_wr_*` on the following edge).
- **Throughput:** one write-back per cycle, sustained.
- **Fairness:** a requester held valid is granted within NUM_REQ cycles.
- **Ready path:** `arb_req_ready` depends combinationally on `arb_req_valid` and `ptr` only, never on addr or data.
- **Hazard path:** hazard outputs are combinational from the check addresses and registered state. They reflect reservations from the previous edge only, not the same cycle's `arb_rsv_en`.

## Test plan
- **Reset:** assert reset mid-write (`arb_wr_en=1`, busy=0x0000_0010) -> all outputs go to 0 asynchronously, before the next edge; the first grant after release goes to requester 0.
- **Round-robin:** all three valid continuously with distinct addrs 1/2/3 -> grants 0,1,2,0,1,2 on consecutive cycles; `arb_wr_en` high every cycle from cycle 2, with matching addr and data.
- **Scoreboard and hazard:**
  - reserve x5, then a write-back to x5 two cycles later with `chk_addr_1=5` -> hazard_1 is 1 from the edge after the reserve, through the `arb_wr_en` cycle;
  - hazard_1 drops the cycle after;
  - busy[5] clears on the handshake edge.
- **Set/clear collision:** reserve x7 in the same cycle as a write-back to x7 -> busy[7] remains 1; a second write-back clears it.
- **x0 handling:**
  - requester 1 writes addr 0 with data 0xDEADBEEF -> ready given, `arb_wr_en` stays 0, ptr advances to 2;
  - `arb_rsv_en` with addr 0 -> busy unchanged, hazard on addr 0 stays 0.
- **Fairness under skew:** requester 2 held valid while requesters 0 and 1 toggle valid every cycle -> requester 2 is granted within 3 cycles, every time.
